// File: rtl/mmio_pkg.sv
// Shared register map, bit positions, parameter bounds and byte-lane helpers
// for the memory-mapped PWM/timer block.
package mmio_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_MICROS = 8'h04;
  localparam logic [7:0] OFF_MILLIS = 8'h08;
  localparam logic [7:0] OFF_CMP    = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_DUTY0  = 8'h20;

  localparam int CTRL_PWM_EN    = 0;
  localparam int CTRL_TIMER_EN  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_CMP_HIT = 0;

  localparam int NUM_CH_MIN   = 1;
  localparam int NUM_CH_MAX   = 8;
  localparam int PWM_BITS_MIN = 4;
  localparam int PWM_BITS_MAX = 16;

  // funct3[1] selects word, funct3[0] half, otherwise a single byte
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
    if (size[1])      return 4'hF;
    else if (size[0]) return addr[1] ? 4'hC : 4'h3;
    else              return 4'b0001 << addr;
  endfunction

  function automatic logic [31:0] lane_align(input logic [1:0] size, input logic [31:0] data,
                                             input logic [1:0] addr);
    if (size[1])      return data;
    else if (size[0]) return addr[1] ? {data[15:0], 16'h0000} : {16'h0000, data[15:0]};
    else              return {24'h000000, data[7:0]} << {addr, 3'b000};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                             input logic [3:0] mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register, period-aligned active duty and the
// registered compare against the shared counter.
module pwm_channel
  import mmio_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [PWM_BITS-1:0] i_wr_data,
  input  logic                i_load,
  input  logic                i_pwm_en,
  input  logic [PWM_BITS-1:0] i_cnt,
  output logic [PWM_BITS-1:0] o_shadow,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_shadow;
  logic [PWM_BITS-1:0] r_active;
  logic                r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr_en) r_shadow <= i_wr_data;
      // active only changes at a period boundary so a cycle never glitches
      if (i_load)  r_active <= r_shadow;
      r_pwm <= i_pwm_en && (i_cnt < r_active);
    end
  end

  assign o_shadow = r_shadow;
  assign o_pwm    = r_pwm;

endmodule

// File: rtl/mmio_pwm_timer.sv
// MMIO PWM generator plus microsecond/millisecond timer with compare interrupt.
// Define MMIO_PWM_TIMER_IRQ_EN to build CMP, STATUS, irq_en and irq.
module mmio_pwm_timer
  import mmio_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          PWM_BITS  = 8,
  parameter int          CLK_HZ    = 12000000,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_mem,
  input  logic [2:0]        funct3,
  input  logic [31:0]       write_address,
  input  logic [31:0]       write_data,
  input  logic [31:0]       read_address,
  output logic [31:0]       read_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("NUM_CH out of range");
  end
  if (PWM_BITS < PWM_BITS_MIN || PWM_BITS > PWM_BITS_MAX) begin : g_bad_pwm_bits
    $error("PWM_BITS out of range");
  end
  if (CLK_HZ < 1000000 || (CLK_HZ % 1000000) != 0) begin : g_bad_clk_hz
    $error("CLK_HZ must be a non-zero multiple of 1 MHz");
  end

  localparam int                  US_DIV  = CLK_HZ / 1000000;
  localparam int                  US_W    = $clog2(US_DIV + 1);
  localparam logic [US_W-1:0]     US_LAST = US_W'(US_DIV - 1);
  localparam logic [9:0]          MS_LAST = 10'd999;
  localparam logic [PWM_BITS-1:0] CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};
`ifdef MMIO_PWM_TIMER_IRQ_EN
  localparam logic [2:0]          CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0]          CTRL_WMASK = 3'b011;
`endif

  logic [2:0]          r_ctrl;
  logic [31:0]         r_micros;
  logic [31:0]         r_millis;
  logic [US_W-1:0]     r_us_pre;
  logic [9:0]          r_ms_pre;
  logic [PWM_BITS-1:0] r_cnt;
  logic [31:0]         r_rdata;

  logic                w_wr_hit;
  logic [7:0]          w_wr_off;
  logic [7:0]          w_rd_off;
  logic [3:0]          w_mask;
  logic [31:0]         w_wdata;
  logic                w_ctrl_we;
  logic [31:0]         w_ctrl_merged;
  logic                w_pwm_en;
  logic                w_timer_en;
  logic                w_us_tick;
  logic                w_ms_tick;
  logic                w_wrap;
  logic                w_load;
  logic [31:0]         w_cmp;
  logic                w_cmp_hit;
  logic [31:0]         w_rdata;
  logic [PWM_BITS-1:0] w_shadow [NUM_CH];
  logic                w_unused;

  assign w_wr_hit      = write_mem && (write_address[31:8] == BASE_ADDR[31:8]);
  assign w_wr_off      = {write_address[7:2], 2'b00};
  assign w_rd_off      = {read_address[7:2], 2'b00};
  assign w_mask        = lane_mask(funct3[1:0], write_address[1:0]);
  assign w_wdata       = lane_align(funct3[1:0], write_data, write_address[1:0]);
  assign w_ctrl_we     = w_wr_hit && (w_wr_off == OFF_CTRL);
  assign w_ctrl_merged = lane_merge({29'b0, r_ctrl}, w_wdata, w_mask);
  assign w_pwm_en      = r_ctrl[CTRL_PWM_EN];
  assign w_timer_en    = r_ctrl[CTRL_TIMER_EN];
  assign w_unused      = ^{funct3[2], read_address[1:0], w_ctrl_merged[31:3]};

  always_ff @(posedge clk) begin
    if (rst)            r_ctrl <= '0;
    else if (w_ctrl_we) r_ctrl <= w_ctrl_merged[2:0] & CTRL_WMASK;
  end

  // Timer: clock-cycle prescaler feeds micros, micro-tick prescaler feeds millis
  assign w_us_tick = w_timer_en && (r_us_pre == US_LAST);
  assign w_ms_tick = w_us_tick && (r_ms_pre == MS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_us_pre <= '0;
      r_ms_pre <= '0;
      r_micros <= '0;
      r_millis <= '0;
    end else if (w_timer_en) begin
      r_us_pre <= w_us_tick ? '0 : r_us_pre + 1'b1;
      if (w_us_tick) begin
        r_micros <= r_micros + 32'd1;
        r_ms_pre <= w_ms_tick ? '0 : r_ms_pre + 10'd1;
      end
      if (w_ms_tick) r_millis <= r_millis + 32'd1;
    end
  end

`ifdef MMIO_PWM_TIMER_IRQ_EN
  logic [31:0] r_cmp;
  logic        r_cmp_hit;
  logic        w_cmp_we;
  logic        w_status_clr;
  logic        w_hit_set;
  logic [31:0] w_cmp_merged;

  assign w_cmp_we     = w_wr_hit && (w_wr_off == OFF_CMP);
  assign w_cmp_merged = lane_merge(r_cmp, w_wdata, w_mask);
  assign w_status_clr = w_wr_hit && (w_wr_off == OFF_STATUS) && w_mask[0] && w_wdata[STATUS_CMP_HIT];
  assign w_hit_set    = w_ms_tick && ((r_millis + 32'd1) == r_cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp     <= '0;
      r_cmp_hit <= 1'b0;
    end else begin
      if (w_cmp_we) r_cmp <= w_cmp_merged;
      // a hit in the same cycle as the clear wins so no event is lost
      if (w_hit_set)         r_cmp_hit <= 1'b1;
      else if (w_status_clr) r_cmp_hit <= 1'b0;
    end
  end

  assign w_cmp     = r_cmp;
  assign w_cmp_hit = r_cmp_hit;
  assign irq       = r_cmp_hit & r_ctrl[CTRL_IRQ_EN];
`else
  assign w_cmp     = '0;
  assign w_cmp_hit = 1'b0;
  assign irq       = 1'b0;
`endif

  // Shared PWM counter: period is 2^PWM_BITS-1 so an all-ones duty is always high
  assign w_wrap = w_pwm_en && (r_cnt == CNT_MAX);
  assign w_load = !w_pwm_en || w_wrap;

  always_ff @(posedge clk) begin
    if (rst || !w_pwm_en) r_cnt <= '0;
    else                  r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic        w_duty_we;
    logic [31:0] w_duty_merged;
    logic        w_unused_duty;

    assign w_duty_we     = w_wr_hit && (w_wr_off == 8'(OFF_DUTY0 + 4 * i));
    assign w_duty_merged = lane_merge(32'(w_shadow[i]), w_wdata, w_mask);
    assign w_unused_duty = ^w_duty_merged[31:PWM_BITS];

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_duty_we),
      .i_wr_data (w_duty_merged[PWM_BITS-1:0]),
      .i_load    (w_load),
      .i_pwm_en  (w_pwm_en),
      .i_cnt     (r_cnt),
      .o_shadow  (w_shadow[i]),
      .o_pwm     (pwm_out[i])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (read_address[31:8] == BASE_ADDR[31:8]) begin
      case (w_rd_off)
        OFF_CTRL:   w_rdata = {29'b0, r_ctrl};
        OFF_MICROS: w_rdata = r_micros;
        OFF_MILLIS: w_rdata = r_millis;
        OFF_CMP:    w_rdata = w_cmp;
        OFF_STATUS: w_rdata = {31'b0, w_cmp_hit};
        default:    w_rdata = '0;
      endcase
      for (int i = 0; i < NUM_CH; i++)
        if (w_rd_off == 8'(OFF_DUTY0 + 4 * i)) w_rdata = 32'(w_shadow[i]);
    end
  end

  // Read port: registered, so a same-cycle write is seen only on the next read
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= w_rdata;
  end

  assign read_data = r_rdata;

endmodule

// File: tb/tb_mmio_pwm_timer.sv
// Directed self-checking bench for mmio_pwm_timer (3 MHz clock so the timer
// scenarios stay short); follows MMIO_PWM_TIMER_IRQ_EN for irq expectations.
module tb_mmio_pwm_timer;

  localparam logic [31:0] BASE = 32'hFFFFFF00;
`ifdef MMIO_PWM_TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_mem = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] write_address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_address = '0;
  logic [31:0] read_data;
  logic [3:0]  pwm_out;
  logic        irq;

  int n_total = 0;
  int n_bad   = 0;

  mmio_pwm_timer #(
    .NUM_CH(4), .PWM_BITS(8), .CLK_HZ(3000000), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .write_mem(write_mem), .funct3(funct3),
    .write_address(write_address), .write_data(write_data),
    .read_address(read_address), .read_data(read_data),
    .pwm_out(pwm_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [2:0] f3);
    write_mem     = 1'b1;
    funct3        = f3;
    write_address = BASE + 32'(off);
    write_data    = data;
    @(posedge clk); #1;
    write_mem     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] val);
    read_address = addr;
    @(posedge clk); #1;
    val = read_data;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic count_hi(input int ch, input int n, output int hits);
    hits = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (pwm_out[ch]) hits++;
    end
  endtask

  task automatic wait_out0(input logic level, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(posedge clk); #1;
      if (pwm_out[0] == level) ok = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] v;
    int          hits;
    bit          ok;

    // reset state
    read_address = BASE + 32'h08;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(BASE + 32'h08, v);       check("rst_millis", v, 32'h0);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // reset overrides a concurrent write
    rst = 1'b1;
    wr(8'h00, 32'h7, 3'b010);
    rst = 1'b0;
    rd(BASE + 32'h00, v);       check("rst_over_wr", v, 32'h0);

    // byte lanes on DUTY0 (8-bit duty) and CTRL
    wr(8'h20, 32'h12345678, 3'b010);
    rd(BASE + 32'h20, v);       check("duty_word", v, 32'h78);
    wr(8'h21, 32'h000000AB, 3'b000);
    rd(BASE + 32'h20, v);       check("duty_byte_hi", v, 32'h78);
    wr(8'h20, 32'h0000005A, 3'b000);
    rd(BASE + 32'h20, v);       check("duty_byte_lo", v, 32'h5A);
    wr(8'h22, 32'h0000BEEF, 3'b001);
    rd(BASE + 32'h20, v);       check("duty_half_hi", v, 32'h5A);
    wr(8'h20, 32'h0000CAFE, 3'b001);
    rd(BASE + 32'h20, v);       check("duty_half_lo", v, 32'hFE);
    wr(8'h01, 32'h00000007, 3'b000);
    rd(BASE + 32'h00, v);       check("ctrl_lane1", v, 32'h0);
    wr(8'h14, 32'hFFFFFFFF, 3'b010);
    rd(BASE + 32'h14, v);       check("unmapped_14", v, 32'h0);
    rd(32'h00000020, v);        check("out_of_window", v, 32'h0);
    wr(8'h04, 32'h1234, 3'b010);
    rd(BASE + 32'h04, v);       check("micros_ro", v, 32'h0);

    // same-cycle read and write returns the old value
    read_address = BASE + 32'h28;
    wr(8'h28, 32'h33, 3'b010);
    check("rd_wr_same", read_data, 32'h0);
    rd(BASE + 32'h28, v);       check("rd_after_wr", v, 32'h33);

    // PWM duty patterns
    pulse_rst();
    wr(8'h20, 32'h80, 3'b010);
    wr(8'h24, 32'hC0, 3'b010);
    wr(8'h28, 32'hFF, 3'b010);
    wr(8'h2C, 32'h00, 3'b010);
    wr(8'h00, 32'h1, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    for (int ch = 0; ch < 4; ch++) begin
      logic [31:0] exp_hi [4] = '{32'd128, 32'd192, 32'd255, 32'd0};
      count_hi(ch, 255, hits);
      check($sformatf("pwm_hi_ch%0d", ch), 32'(hits), exp_hi[ch]);
    end

    // DUTY1 rewritten mid-period: old 0xC0 holds until wrap
    wait_out0(1'b1, ok);        check("wait_rise", 32'(ok), 32'h1);
    wait_out0(1'b0, ok);        check("wait_fall", 32'(ok), 32'h1);
    wr(8'h24, 32'h40, 3'b010);
    hits = 0;
    ok   = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk); #1;
      if (pwm_out[0]) ok = 1'b1;
      else if (pwm_out[1]) hits++;
    end
    check("wrap_seen", 32'(ok), 32'h1);
    check("old_duty_tail", 32'(hits), 32'd62);
    count_hi(1, 255, hits);     check("new_duty_period", 32'(hits), 32'd64);

    // mid-period reset drops outputs and read_data
    read_address = BASE + 32'h28;
    @(posedge clk); #1;
    check("pre_rst_rdata", read_data, 32'hFF);
    pulse_rst();
    check("midrst_pwm", 32'(pwm_out), 32'h0);
    check("midrst_rdata", read_data, 32'h0);
    rd(BASE + 32'h20, v);       check("midrst_duty0", v, 32'h0);

    // timer: 30000 enabled cycles at 3 MHz = 10000 us = 10 ms
    wr(8'h00, 32'h2, 3'b010);
    repeat (29999) @(posedge clk);
    #1;
    wr(8'h00, 32'h0, 3'b010);
    rd(BASE + 32'h04, v);       check("micros_10ms", v, 32'd10000);
    rd(BASE + 32'h08, v);       check("millis_10ms", v, 32'd10);
    repeat (50) @(posedge clk);
    #1;
    rd(BASE + 32'h04, v);       check("micros_frozen", v, 32'd10000);
    rd(BASE + 32'h08, v);       check("millis_frozen", v, 32'd10);

    // compare interrupt, with a W1C landing on the hit cycle
    pulse_rst();
    wr(8'h0C, 32'd3, 3'b010);
    wr(8'h00, 32'h6, 3'b010);
    repeat (8999) @(posedge clk);
    #1;
    check("irq_before_hit", 32'(irq), 32'h0);
    wr(8'h10, 32'h1, 3'b010);
    check("irq_on_hit", 32'(irq), IRQ_ON ? 32'h1 : 32'h0);
    rd(BASE + 32'h08, v);       check("millis_at_hit", v, 32'd3);
    rd(BASE + 32'h10, v);       check("status_set_wins", v, IRQ_ON ? 32'h1 : 32'h0);
    rd(BASE + 32'h0C, v);       check("cmp_read", v, IRQ_ON ? 32'd3 : 32'd0);
    rd(BASE + 32'h00, v);       check("ctrl_read", v, IRQ_ON ? 32'h6 : 32'h2);
    wr(8'h10, 32'h1, 3'b010);
    rd(BASE + 32'h10, v);       check("status_w1c", v, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
